// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a little-endian byte stream (word count, then words)
// into 32-bit imem writes while holding the core; reports done or oversize error.
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_rx_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_core_hold;
  logic        r_load_done;
  logic        r_load_err;
  logic [15:0] r_words_loaded;

  logic [31:0] r_count;
  logic [23:0] r_word;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_index;

  logic        w_xfer;
  logic        w_last_byte;
  logic [31:0] w_hdr_full;
  logic [15:0] w_idx_next;
  logic        w_start;

  assign w_xfer      = rx_valid & r_rx_ready;
  assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
  assign w_hdr_full  = {rx_data, r_count[31:8]};
  assign w_idx_next  = r_index + 16'd1;
  assign w_start     = load_start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) w_next = S_HEADER;
      end
      S_HEADER: begin
        if (w_last_byte) begin
          if (w_hdr_full == 32'd0)        w_next = S_DONE;
          else if (w_hdr_full > LP_DEPTH) w_next = S_ERR;
          else                            w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: begin
        if ({16'd0, w_idx_next} == r_count) w_next = S_DONE;
        else                                w_next = S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= 32'd0;
      r_imem_wdata   <= 32'd0;
      r_core_hold    <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
      r_words_loaded <= 16'd0;
      r_count        <= 32'd0;
      r_word         <= 24'd0;
      r_byte_cnt     <= 2'd0;
      r_index        <= 16'd0;
    end else begin
      r_rx_ready  <= (w_next == S_HEADER) || (w_next == S_DATA);
      r_imem_we   <= (w_next == S_WRITE);
      r_core_hold <= (w_next == S_HEADER) || (w_next == S_DATA) ||
                     (w_next == S_WRITE)  || (w_next == S_ERR);
      r_load_done <= (w_next == S_DONE);
      r_load_err  <= (w_next == S_ERR);

      if (w_start) begin
        r_count        <= 32'd0;
        r_byte_cnt     <= 2'd0;
        r_index        <= 16'd0;
        r_words_loaded <= 16'd0;
      end

      if (r_state == S_HEADER && w_xfer) begin
        r_count    <= w_hdr_full;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      if (r_state == S_DATA && w_xfer) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_imem_wdata <= {rx_data, r_word};
          r_imem_addr  <= BASE_ADDR + {14'd0, r_index, 2'b00};
        end else begin
          r_word <= {rx_data, r_word[23:8]};
        end
      end

      if (r_state == S_WRITE) begin
        r_index        <= w_idx_next;
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign core_hold    = r_core_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load sessions plus reset/restart sequences; expected
// imem writes are queued as bytes are sent and checked as the loader emits them.
module tb_imem_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH_WORDS(256),
    .BASE_ADDR  (TB_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_hold   (core_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  typedef struct {
    logic [31:0] n;
    bit          gaps;
    bit          rnd;
    bit          mid_start;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hold;
    logic [15:0] exp_wl;
    int          exp_lat;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [63:0] sb_q[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, any write popped from the scoreboard.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (imem_we) begin
      n_writes++;
      check("rx_ready_during_write", 32'(rx_ready), 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = sb_q.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    bit acc;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    do begin
      acc = rx_ready;
      step();
      k++;
    end while (!acc && k < 50);
    rx_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte 0x%02h not taken in 50 cycles, expected accept", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit pulse);
    for (int k = 0; k < 4; k++) begin
      if (pulse && k == 1) load_start = 1'b1;
      send_byte(w[8*k +: 8], gaps);
      load_start = 1'b0;
    end
  endtask

  task automatic run_session(input vec_t v);
    logic [31:0] hdr;
    logic [31:0] w;
    int          lat;
    n_writes   = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("start_core_hold", 32'(core_hold), 32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    check("start_load_done", 32'(load_done), 32'd0);
    check("start_load_err", 32'(load_err), 32'd0);
    check("start_words_loaded", 32'(words_loaded), 32'd0);
    hdr = v.n;
    for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], v.gaps);
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.n); i++) begin
        if (!v.rnd && i == 0)      w = 32'h0000_0013;
        else if (!v.rnd && i == 1) w = 32'h0010_0093;
        else                       w = $urandom;
        sb_q.push_back({TB_BASE + 32'(i) * 32'd4, w});
        send_word(w, v.gaps, v.mid_start && i == 0);
      end
    end
    lat = 0;
    while (!(load_done || load_err) && lat < 8) begin
      step();
      lat++;
    end
    check("end_latency", 32'(lat), 32'(v.exp_lat));
    check("end_load_done", 32'(load_done), 32'(v.exp_done));
    check("end_load_err", 32'(load_err), 32'(v.exp_err));
    check("end_core_hold", 32'(core_hold), 32'(v.exp_hold));
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    check("end_words_loaded", 32'(words_loaded), 32'(v.exp_wl));
    check("end_write_count", 32'(n_writes), 32'(v.exp_wl));
    check("end_scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    vec_t v;
    //           n             gaps rnd mid done err hold wl      lat
    vecs[0] = '{32'd2,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2,   1};
    vecs[1] = '{32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   0};
    vecs[2] = '{32'd257,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,   0};
    vecs[3] = '{32'd2,          1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2,   1};
    vecs[4] = '{32'h0001_0001,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,   0};
    vecs[5] = '{32'd256,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd256, 1};
    vecs[6] = '{32'd3,          1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3,   1};
    vecs[7] = '{32'd2,          1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2,   1};

    reset      = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    #12;
    check_all_zero("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    check("idle_core_hold", 32'(core_hold), 32'd0);

    foreach (vecs[i]) run_session(vecs[i]);

    // Reset after two bytes of word 1: word 0 stays written, word 1 never appears.
    n_writes   = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'h02 : 8'h00, 1'b0);
    sb_q.push_back({TB_BASE, 32'hAABB_CCDD});
    send_word(32'hAABB_CCDD, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    check("midreset_word0_written", 32'(n_writes), 32'd1);
    check("midreset_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    step();
    step();
    reset = 1'b0;
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    repeat (3) step();
    rx_valid = 1'b0;
    check("postreset_no_write", 32'(n_writes), 32'd1);
    check("postreset_core_hold", 32'(core_hold), 32'd0);
    check("postreset_rx_ready", 32'(rx_ready), 32'd0);

    v = '{32'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1};
    run_session(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
